mem_copy_engine: RTL and testbench

- Initiator-side master for the single-cycle CPU's byte-addressed data memory: drives address, write data and the read/write strobes, and consumes the memory's read data.
- Copies a block of 32-bit words from a source to a destination region on a start command. Two cycles per word: a read cycle, then a write cycle.
- Used for testbench preload/relocation and as the DMA path beside the CPU. Memory ports are muxed to this block when busy_o=1.

---
 rtl/mem_copy_engine.sv | 108 ++++++++++
 tb/tb_mem_copy_engine.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-block copy master for the data memory, read then write per word.
// Optional MEMCPY_CHECKSUM_EN adds checksum_o, the mod-2^32 sum of the words written.
module mem_copy_engine #(
  parameter int MEM_BYTES = 128,
  parameter int LEN_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic [31:0]      mem_data_i,
  output logic             MemRead_o,
  output logic             MemWrite_o
`ifdef MEMCPY_CHECKSUM_EN
  ,
  output logic [31:0]      checksum_o
`endif
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic [31:0] sp, dp;
  logic [LEN_W-1:0] len_q;
  logic [32:0] src_end, dst_end, span;
  logic ok;
  assign span = {{(31-LEN_W){1'b0}}, len_i, 2'b00};
  assign src_end = {1'b0, src_i} + span;
  assign dst_end = {1'b0, dst_i} + span;
  assign ok = src_end <= 33'(MEM_BYTES) && dst_end <= 33'(MEM_BYTES) && src_i[1:0] == 2'b00 && dst_i[1:0] == 2'b00;
  // mem_data_o doubles as the word buffer: it is loaded at the READ edge and driven during WRITE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      words_o <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      MemRead_o <= 1'b0;
      MemWrite_o <= 1'b0;
      sp <= '0;
      dp <= '0;
      len_q <= '0;
`ifdef MEMCPY_CHECKSUM_EN
      checksum_o <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start_i) begin
          sp <= src_i;
          dp <= dst_i;
          len_q <= len_i;
          words_o <= '0;
          err_o <= !ok;
`ifdef MEMCPY_CHECKSUM_EN
          checksum_o <= '0;
`endif
          if (ok && len_i != '0) begin
            state <= READ;
            busy_o <= 1'b1;
            MemRead_o <= 1'b1;
            mem_addr_o <= src_i;
          end else begin
            state <= DONE;
            done_o <= 1'b1;
          end
        end
        READ: begin
          mem_data_o <= mem_data_i;
          sp <= sp + 32'd4;
          state <= WRITE;
          MemRead_o <= 1'b0;
          MemWrite_o <= 1'b1;
          mem_addr_o <= dp;
        end
        WRITE: begin
          dp <= dp + 32'd4;
          words_o <= words_o + LEN_W'(1);
          MemWrite_o <= 1'b0;
`ifdef MEMCPY_CHECKSUM_EN
          checksum_o <= checksum_o + mem_data_o;
`endif
          if (words_o + LEN_W'(1) == len_q) begin
            state <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state <= READ;
            MemRead_o <= 1'b1;
            mem_addr_o <= sp;
          end
        end
        default: begin
          done_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed copy commands checked against a shadow memory and a write scoreboard.
`define CHK(t, o, e) begin checks++; assert ((o) === (e)) else begin errors++; $error("FAIL %s got=%0h exp=%0h", t, o, e); end end
module tb_mem_copy_engine;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [5:0] len = '0;
  logic busy_o, done_o, err_o, MemRead_o, MemWrite_o;
  logic [5:0] words_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
`ifdef MEMCPY_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif
  logic [31:0] mem [32];
  logic [31:0] shadow [32];
  logic [63:0] sb [$];
  int checks = 0, errors = 0;
  mem_copy_engine dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src_i(src), .dst_i(dst), .len_i(len),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o)
`ifdef MEMCPY_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );
  always #5 clk = ~clk;
  assign mem_data_i = MemRead_o ? mem[mem_addr_o[6:2]] : 32'h0;
  always @(posedge clk) if (MemWrite_o) mem[mem_addr_o[6:2]] <= mem_data_o;
  always @(negedge clk) begin
    `CHK("excl", MemRead_o & MemWrite_o, 1'b0)
    if (MemWrite_o) begin
      `CHK("sb_has", sb.size() != 0, 1'b1)
      if (sb.size() != 0) `CHK("sb_wr", {mem_addr_o, mem_data_o}, sb.pop_front())
    end
  end
  task automatic cmd(input logic [31:0] s, input logic [31:0] d, input logic [5:0] l, input bit e, input int pulse, input int abort);
    int cyc, busy_n, rd_n, wr_n, done_at, extra, bad;
    logic [31:0] sum, v;
    sum = '0;
    for (int i = 0; i < 32; i++) shadow[i] = mem[i];
    if (!e) for (int i = 0; i < int'(l); i++) begin
      v = shadow[s[6:2] + 5'(i)];
      sb.push_back({d + 32'(4 * i), v});
      sum += v;
      if (abort == 0 || 2 * i + 2 < abort) shadow[d[6:2] + 5'(i)] = v;
    end
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busy_n = 0; rd_n = 0; wr_n = 0; done_at = 0; extra = 0;
    while (done_at == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse);
      if (cyc == pulse) begin src = 32'h4; dst = 32'h8; len = 6'd1; end
      if (cyc == abort) begin
        #2 rst = 1'b1;
        #1;
        `CHK("abort_out", {busy_o, done_o, err_o, MemRead_o, MemWrite_o, words_o, mem_addr_o, mem_data_o}, 76'h0)
        `CHK("abort_left", sb.size(), 2)
        sb.delete();
        @(negedge clk) rst = 1'b0;
        break;
      end
      busy_n += int'(busy_o);
      rd_n += int'(MemRead_o);
      wr_n += int'(MemWrite_o);
      if (done_o) begin
        done_at = cyc;
        `CHK("err", err_o, e)
        `CHK("words", words_o, e ? 6'd0 : l)
`ifdef MEMCPY_CHECKSUM_EN
        `CHK("csum", checksum_o, sum)
`endif
      end
    end
    if (abort == 0) begin
      `CHK("done_cyc", done_at, (e || l == 0) ? 1 : 2 * int'(l) + 1)
      `CHK("busy_n", busy_n, (e || l == 0) ? 0 : 2 * int'(l))
      `CHK("rd_n", rd_n, e ? 0 : int'(l))
      `CHK("wr_n", wr_n, e ? 0 : int'(l))
      repeat (6) begin
        @(negedge clk);
        extra += int'(done_o | busy_o | MemRead_o | MemWrite_o);
      end
      `CHK("quiet", extra, 0)
      `CHK("sb_drain", sb.size(), 0)
    end
    bad = 0;
    for (int i = 0; i < 32; i++) bad += int'(mem[i] !== shadow[i]);
    `CHK("mem", bad, 0)
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5000000 + 32'(i);
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333; mem[3] = 32'h44444444;
    #12;
    `CHK("rst_out", {busy_o, done_o, err_o, MemRead_o, MemWrite_o, words_o, mem_addr_o, mem_data_o}, 76'h0)
    @(negedge clk) rst = 1'b0;
    cmd(32'h00, 32'h40, 6'd4, 1'b0, 0, 0);
    `CHK("w19", mem[19], 32'h44444444)
    cmd(32'h10, 32'h20, 6'd0, 1'b0, 0, 0);
    cmd(32'h02, 32'h40, 6'd1, 1'b1, 0, 0);
    cmd(32'h70, 32'h00, 6'd5, 1'b1, 0, 0);
    `CHK("err_sticky", err_o, 1'b1)
    cmd(32'h7C, 32'h00, 6'd1, 1'b0, 0, 0);
    mem[0] = 32'hDEADBEEF; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    cmd(32'h00, 32'h04, 6'd3, 1'b0, 0, 0);
    `CHK("ovl3", mem[3], 32'hDEADBEEF)
    cmd(32'h20, 32'h60, 6'd4, 1'b0, 3, 0);
    cmd(32'h00, 32'h50, 6'd4, 1'b0, 0, 5);
    cmd(32'h40, 32'h00, 6'd4, 1'b0, 0, 0);
    `CHK("w0", mem[0], 32'h11111111)
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
